display_scan_controller: RTL and testbench
==========================================

// Module: display_scan_controller
// PURPOSE
//  Scan controller that drives the multiplexed 4-digit 7-segment display.
//  Generates the 2-bit digit select consumed by the screen segment decoders
//  (sel[1] = first counter bit, sel[0] = second counter bit).
//  Drives the active-low digit enables with an anti-ghosting blank window.
//  Commits requested screen codes only at frame boundaries, so a screen never tears mid-scan.
// PARAMETERS
//  CLK_HZ        50_000_000  input clock frequency
//  SCAN_HZ       1_000       digit slot rate; DIV = CLK_HZ/SCAN_HZ cycles per slot (DIV >= BLANK_CYCLES+2)
//  BLANK_CYCLES  16          cycles at start of each slot with all digits disabled
//  SCREEN_W      3           width of screen code
// PORTS
//  clock         in   1         system clock, rising edge
//  reset_n       in   1         asynchronous active-low reset
//  enable        in   1         1 = scan runs; 0 = prescaler held, all digits off
//  screen_req    in   SCREEN_W  requested screen code
//  screen_valid  in   1         request valid
//  screen_ready  out  1         controller can accept a request
//  active_screen out  SCREEN_W  screen code currently shown (feeds decoder select)
//  sel           out  2         digit select to segment decoders
//  digit_en_n    out  4         digit enables, active low; bit k = digit selected by sel==k
//  frame_tick    out  1         one-cycle pulse at each frame boundary
// BEHAVIOUR
//  Reset (async, any time, incl. mid-slot or with a request pending):
//   - prescaler=0, sel=0, digit_en_n=4'hF, active_screen=0
//   - pending empty, screen_ready=1, frame_tick=0
//  Prescaler:
//   - counts 0..DIV-1 while enable=1; held when enable=0
//   - at DIV-1: wraps to 0 and sel <= sel+1 (wraps 3->0)
//  Blanking, registered outputs:
//   - digit_en_n=4'hF while prescaler < BLANK_CYCLES or enable=0
//   - otherwise digit_en_n = ~(4'b0001 << sel)
//   - sel never changes while any digit is enabled
//  Frame boundary:
//   - the cycle in which the prescaler wraps and sel goes 3->0
//   - frame_tick=1 for exactly that one cycle
//   - if pending full: active_screen <= pending; pending cleared; screen_ready returns 1 next cycle
//  Handshake:
//   - accept when screen_valid & screen_ready; screen_req captured into pending; screen_ready=0 next cycle
//   - screen_ready = ~pending_full (registered)
//   - accept coinciding with a frame boundary: commit uses the pre-cycle pending
//     (empty -> no change); the new request is committed at the following boundary
//   - valid while not ready: ignored; requester holds
//  enable=0 mid-slot:
//   - slot resumes from the held prescaler value; no frame_tick while disabled
//   - a commit never occurs while disabled
//  Latency: request accepted -> active_screen updated at the next frame boundary, at most 4*DIV cycles.
// STRUCTURE
//  - Shared package: SCREEN_W; screen code constants (SCR_S0=0 and successors); NUM_DIGITS=4; DIGIT_OFF=4'hF.
//  - Sub-module scan_prescaler: parameterised DIV counter with hold enable and wrap pulse.
//  - Remainder (sel, blanking, pending register, commit) in this module.
// TESTING  (CLK_HZ=16, SCAN_HZ=2 -> DIV=8, BLANK_CYCLES=2)
//  - Reset then enable=1, 40 cycles -> sel 0,1,2,3,0 every 8 cycles; each slot shows digit_en_n=F for 2 cycles
//    then 1110/1101/1011/0111; frame_tick once, at cycle 31.
//  - screen_req=2 valid at cycle 5 -> ready low cycle 6; active_screen stays 0 until boundary at cycle 31,
//    then 2; ready high cycle 32.
//  - Request accepted in the frame_tick cycle -> active_screen unchanged this boundary; updated at the
//    next one, 32 cycles later.
//  - enable=0 for 10 cycles mid-slot 1 -> digit_en_n=F, sel held at 1; after re-enable the slot completes
//    its remaining cycles.
//  - reset_n low mid-slot 2 with a request pending -> outputs immediately return to reset values;
//    pending discarded; active_screen=0.
//  - Back-to-back valid while ready=0 -> only the first request is captured and committed.

Source files
------------

// File: rtl/display_scan_controller_pkg.sv
// -----------------------------------------------------------------------------
// display_scan_controller_pkg
// Shared constants and types for the multiplexed 4-digit 7-segment scan
// controller: screen code width and named codes, digit count and the
// all-digits-off enable pattern.
// -----------------------------------------------------------------------------
package display_scan_controller_pkg;

    localparam int SCREEN_W   = 3;
    localparam int NUM_DIGITS = 4;

    // Active-low digit enables: every digit dark.
    localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = 4'hF;

    // Screen codes understood by the downstream segment decoders.
    typedef enum logic [SCREEN_W-1:0] {
        SCR_S0 = 3'd0,
        SCR_S1 = 3'd1,
        SCR_S2 = 3'd2,
        SCR_S3 = 3'd3,
        SCR_S4 = 3'd4,
        SCR_S5 = 3'd5,
        SCR_S6 = 3'd6,
        SCR_S7 = 3'd7
    } screen_e;

endpackage

// File: rtl/display_scan_controller_scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Divide-by-DIV slot counter. Counts 0..DIV-1 while i_en is high and holds its
// value while i_en is low. o_wrap is high in the cycle whose clock edge takes
// the counter from DIV-1 back to 0. o_count_next is the value the counter will
// hold after the coming edge, so the parent can register outputs that line up
// with the counter instead of lagging it by one cycle.
//
// Ports
//   i_clock       in   system clock, rising edge
//   i_reset_n     in   asynchronous active-low reset
//   i_en          in   1 = count, 0 = hold
//   o_count_next  out  counter value after the next edge
//   o_wrap        out  counter is at DIV-1 and is about to wrap
// -----------------------------------------------------------------------------
module scan_prescaler #(
    parameter int DIV   = 8,
    parameter int CNT_W = 3
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count_next,
    output logic             o_wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             w_last;

    assign w_last = (r_count == LAST);

    always_comb begin
        w_count_next = r_count;
        if (i_en) begin
            w_count_next = w_last ? '0 : r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count_next = w_count_next;
    assign o_wrap       = i_en & w_last;

endmodule

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
// Scan controller for a multiplexed 4-digit 7-segment display. Steps a 2-bit
// digit select once per slot, drives active-low digit enables with a blank
// window at the start of every slot (anti-ghosting), and holds a one-deep
// pending screen request that is committed to o_active_screen only at a frame
// boundary so a screen never changes part-way through a scan.
//
// Ports
//   i_clock          in   system clock, rising edge
//   i_reset_n        in   asynchronous active-low reset
//   i_enable         in   1 = scan runs, 0 = prescaler held and digits off
//   i_screen_req     in   requested screen code
//   i_screen_valid   in   request valid
//   o_screen_ready   out  controller can accept a request (pending slot empty)
//   o_active_screen  out  screen code currently shown
//   o_sel            out  digit select to the segment decoders
//   o_digit_en_n     out  digit enables, active low, bit k <-> o_sel == k
//   o_frame_tick     out  high in the cycle that ends a frame (sel 3 -> 0)
// -----------------------------------------------------------------------------
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 1_000,
    parameter int BLANK_CYCLES = 16,
    parameter int SCREEN_WIDTH = SCREEN_W
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic                    i_enable,
    input  logic [SCREEN_WIDTH-1:0] i_screen_req,
    input  logic                    i_screen_valid,
    output logic                    o_screen_ready,
    output logic [SCREEN_WIDTH-1:0] o_active_screen,
    output logic [1:0]              o_sel,
    output logic [NUM_DIGITS-1:0]   o_digit_en_n,
    output logic                    o_frame_tick
);

    // Slot length in clocks; must be at least BLANK_CYCLES+2 so every slot
    // lights its digit for at least two cycles.
    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0]        w_count_next;
    logic                    w_wrap;
    logic                    w_frame_boundary;
    logic [1:0]              w_sel_next;
    logic                    w_blank_next;
    logic [NUM_DIGITS-1:0]   w_digit_en_n_next;
    logic                    w_accept;
    logic                    w_commit;
    logic                    w_pending_full_next;

    logic [1:0]              r_sel;
    logic [NUM_DIGITS-1:0]   r_digit_en_n;
    logic [SCREEN_WIDTH-1:0] r_active_screen;
    logic [SCREEN_WIDTH-1:0] r_pending;
    logic                    r_pending_full;
    logic                    r_screen_ready;

    scan_prescaler #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_scan_prescaler (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_en         (i_enable),
        .o_count_next (w_count_next),
        .o_wrap       (w_wrap)
    );

    // The last slot of a frame wrapping is the frame boundary. w_wrap already
    // carries i_enable, so no boundary (and no commit) happens while disabled.
    assign w_frame_boundary = w_wrap & (r_sel == 2'd3);

    assign w_sel_next = w_wrap ? r_sel + 2'd1 : r_sel;

    // The enables are registered from next-cycle counter/select values so they
    // line up with the slot position. A slot always restarts at count 0, which
    // lies inside the blank window, so sel only ever moves while all digits
    // are dark.
    assign w_blank_next = ~i_enable | (w_count_next < BLANK_END);

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_en
        assign w_digit_en_n_next[gi] = w_blank_next | (w_sel_next != 2'(gi));
    end

    // A request can only be accepted while the pending slot is empty, and a
    // commit only drains a slot that was already full before this cycle, so
    // an accept landing on a boundary waits for the following boundary.
    assign w_accept = i_screen_valid & r_screen_ready;
    assign w_commit = w_frame_boundary & r_pending_full;

    always_comb begin
        w_pending_full_next = r_pending_full;
        if (w_accept) begin
            w_pending_full_next = 1'b1;
        end else if (w_commit) begin
            w_pending_full_next = 1'b0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sel           <= 2'd0;
            r_digit_en_n    <= DIGIT_OFF;
            r_active_screen <= SCREEN_WIDTH'(SCR_S0);
            r_pending       <= '0;
            r_pending_full  <= 1'b0;
            r_screen_ready  <= 1'b1;
        end else begin
            r_sel          <= w_sel_next;
            r_digit_en_n   <= w_digit_en_n_next;
            r_pending_full <= w_pending_full_next;
            r_screen_ready <= ~w_pending_full_next;
            if (w_accept) begin
                r_pending <= i_screen_req;
            end
            if (w_commit) begin
                r_active_screen <= r_pending;
            end
        end
    end

    assign o_sel           = r_sel;
    assign o_digit_en_n    = r_digit_en_n;
    assign o_active_screen = r_active_screen;
    assign o_screen_ready  = r_screen_ready;
    assign o_frame_tick    = w_frame_boundary;

endmodule

// File: tb/tb_display_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_display_scan_controller
// Directed bench for display_scan_controller with DIV=8, BLANK_CYCLES=2.
// Cycle c is the clock period starting with the c-th rising edge after reset
// release (cycle 0 = prescaler 0, sel 0). Inputs are driven 1 time unit after
// the rising edge, outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_display_scan_controller;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [2:0] screen_req;
    logic       screen_valid;
    logic       screen_ready;
    logic [2:0] active_screen;
    logic [1:0] sel;
    logic [3:0] digit_en_n;
    logic       frame_tick;

    int n_checks = 0;
    int n_pass   = 0;

    display_scan_controller #(
        .CLK_HZ       (16),
        .SCAN_HZ      (2),
        .BLANK_CYCLES (2),
        .SCREEN_WIDTH (3)
    ) dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_enable        (enable),
        .i_screen_req    (screen_req),
        .i_screen_valid  (screen_valid),
        .o_screen_ready  (screen_ready),
        .o_active_screen (active_screen),
        .o_sel           (sel),
        .o_digit_en_n    (digit_en_n),
        .o_frame_tick    (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, check the reset values, release into cycle 0
    // with the scan enabled.
    task automatic do_reset();
        rst_n        = 1'b0;
        enable       = 1'b0;
        screen_valid = 1'b0;
        screen_req   = 3'd0;
        next_cycle();
        #1;
        check_val("rst_sel", {30'd0, sel}, 32'd0);
        check_val("rst_en", {28'd0, digit_en_n}, 32'hF);
        check_val("rst_ready", {31'd0, screen_ready}, 32'd1);
        check_val("rst_active", {29'd0, active_screen}, 32'd0);
        check_val("rst_tick", {31'd0, frame_tick}, 32'd0);
        next_cycle();
        rst_n  = 1'b1;
        enable = 1'b1;
    endtask

    // Expected enables for slot position cnt in digit slot s (not disabled).
    function automatic logic [3:0] exp_enables(input int cnt, input int s);
        logic [3:0] one;
        one = 4'b0001;
        if (cnt < 2) return 4'hF;
        return ~(one << s);
    endfunction

    initial begin
        logic [1:0] exp_sel;
        int         t;

        // ---- Free-running scan plus a request at cycle 5 --------------------
        do_reset();
        for (int c = 0; c < 40; c++) begin
            if (c > 0) next_cycle();
            screen_valid = (c == 5);
            screen_req   = 3'd2;
            #1;
            if (c == 5) $display("txn: cycle %0d request screen %0d", c, 2);
            exp_sel = 2'((c / 8) % 4);
            check_val($sformatf("scan_sel@%0d", c), {30'd0, sel}, {30'd0, exp_sel});
            check_val($sformatf("scan_en@%0d", c), {28'd0, digit_en_n},
                      {28'd0, exp_enables(c % 8, int'(exp_sel))});
            check_val($sformatf("scan_tick@%0d", c), {31'd0, frame_tick}, (c == 31) ? 32'd1 : 32'd0);
            check_val($sformatf("req_active@%0d", c), {29'd0, active_screen}, (c >= 32) ? 32'd2 : 32'd0);
            check_val($sformatf("req_ready@%0d", c), {31'd0, screen_ready},
                      (c >= 6 && c < 32) ? 32'd0 : 32'd1);
        end

        // ---- Request accepted in the frame_tick cycle (63) ------------------
        for (int c = 40; c < 100; c++) begin
            next_cycle();
            screen_valid = (c == 63);
            screen_req   = 3'd5;
            #1;
            if (c == 63) $display("txn: cycle %0d request screen %0d on boundary", c, 5);
            check_val($sformatf("bnd_tick@%0d", c), {31'd0, frame_tick},
                      (c == 63 || c == 95) ? 32'd1 : 32'd0);
            check_val($sformatf("bnd_active@%0d", c), {29'd0, active_screen}, (c >= 96) ? 32'd5 : 32'd2);
            check_val($sformatf("bnd_ready@%0d", c), {31'd0, screen_ready},
                      (c >= 64 && c < 96) ? 32'd0 : 32'd1);
        end

        // ---- enable low for cycles 12..21 (mid slot 1) ----------------------
        do_reset();
        for (int c = 0; c < 46; c++) begin
            if (c > 0) next_cycle();
            enable = !(c >= 12 && c <= 21);
            #1;
            t = (c <= 12) ? c : ((c <= 22) ? 12 : c - 10);
            check_val($sformatf("hold_sel@%0d", c), {30'd0, sel}, 32'((t / 8) % 4));
            check_val($sformatf("hold_en@%0d", c), {28'd0, digit_en_n},
                      (c >= 13 && c <= 22) ? 32'hF : {28'd0, exp_enables(t % 8, (t / 8) % 4)});
            check_val($sformatf("hold_tick@%0d", c), {31'd0, frame_tick}, (c == 41) ? 32'd1 : 32'd0);
        end
        $display("txn: enable dropped for 10 cycles in slot 1");

        // ---- Async reset mid slot 2 with a request pending ------------------
        do_reset();
        for (int c = 0; c < 20; c++) begin
            if (c > 0) next_cycle();
            screen_valid = (c == 3);
            screen_req   = 3'd6;
            #1;
            if (c == 3) $display("txn: cycle %0d request screen %0d before reset", c, 6);
            if (c == 4) check_val("pre_rst_ready", {31'd0, screen_ready}, 32'd0);
        end
        check_val("pre_rst_sel", {30'd0, sel}, 32'd2);
        check_val("pre_rst_en", {28'd0, digit_en_n}, 32'hB);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("async_sel", {30'd0, sel}, 32'd0);
        check_val("async_en", {28'd0, digit_en_n}, 32'hF);
        check_val("async_ready", {31'd0, screen_ready}, 32'd1);
        check_val("async_active", {29'd0, active_screen}, 32'd0);
        check_val("async_tick", {31'd0, frame_tick}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) next_cycle();
            #1;
            check_val($sformatf("post_rst_active@%0d", c), {29'd0, active_screen}, 32'd0);
            check_val($sformatf("post_rst_ready@%0d", c), {31'd0, screen_ready}, 32'd1);
            check_val($sformatf("post_rst_tick@%0d", c), {31'd0, frame_tick}, (c == 31) ? 32'd1 : 32'd0);
        end

        // ---- Valid held while not ready: only the first request lands ------
        do_reset();
        for (int c = 0; c < 72; c++) begin
            if (c > 0) next_cycle();
            screen_valid = (c >= 2 && c <= 6);
            screen_req   = 3'(c + 1);
            #1;
            if (c >= 2 && c <= 6) $display("txn: cycle %0d valid screen %0d ready %0d", c, c + 1, screen_ready);
            check_val($sformatf("b2b_ready@%0d", c), {31'd0, screen_ready},
                      (c >= 3 && c < 32) ? 32'd0 : 32'd1);
            check_val($sformatf("b2b_active@%0d", c), {29'd0, active_screen}, (c >= 32) ? 32'd3 : 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
